lsu_dc_parity_pipe: RTL

Pipelined, parametrised dcache parity generator/checker for the LSU fill and read paths. Each input beat is WIDTH*NUM data bits split into NUM groups; the block computes one parity bit per group. The parity sense (even or odd) is selectable per beat. In check mode, the block compares against the supplied parity, produces a per-group error mask, and maintains a saturating error counter and a sticky first-error log. Beats flow through a valid/ready pipeline of configurable depth with full backpressure.

---
 rtl/lsu_par_pkg.sv | 27 ++
 rtl/lsu_dc_parity_stage.sv | 39 +++
 rtl/lsu_dc_parity_pipe.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lsu_par_pkg.sv
// Shared constants and helpers for the dcache parity pipeline.
// Half-split widths and the parity reduction live here so both pipeline variants agree.
package lsu_par_pkg;

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 2;
  // Widest parity group par_reduce can fold; narrower groups are zero-extended.
  localparam int PAR_MAX_W  = 64;

  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

  // Lower half of a group; an odd extra bit lands in the upper half.
  function automatic int half_lo_w(input int width);
    return width / 2;
  endfunction

  function automatic int half_hi_w(input int width);
    return width - (width / 2);
  endfunction

  function automatic logic par_reduce(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/lsu_dc_parity_stage.sv
// One valid/ready register slice; holds while the consumer stalls and refills
// whenever it is empty, so bubbles collapse.
module lsu_dc_parity_stage
  import lsu_par_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_payload,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_payload
);

  logic          vld_reg;
  logic [DW-1:0] payload_reg;

  assign in_rdy      = ~reset & (~vld_reg | out_rdy);
  assign out_vld     = vld_reg;
  assign out_payload = payload_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg <= 1'b0;
    end else if (in_rdy) begin
      vld_reg <= in_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (in_vld && in_rdy) begin
      payload_reg <= in_payload;
    end
  end

endmodule

// File: rtl/lsu_dc_parity_pipe.sv
// Pipelined dcache parity generator/checker with saturating error counter
// and sticky first-error log, updated on the output handshake only.
module lsu_dc_parity_pipe
  import lsu_par_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM    = 16,
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input  logic                   rclk,
  input  logic                   reset,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [WIDTH*NUM-1:0]   in_data,
  input  logic [NUM-1:0]         in_par,
  input  logic                   in_chk,
  input  logic                   in_odd,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [WIDTH*NUM-1:0]   out_data,
  output logic [NUM-1:0]         out_par,
  output logic [NUM-1:0]         out_err,
  output logic                   out_any_err,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   err_log_vld,
  output logic [NUM-1:0]         err_log_mask,
  input  logic                   err_clr
);

  localparam int DW     = WIDTH * NUM;
  localparam int LO_W   = half_lo_w(WIDTH);
  localparam int HI_W   = half_hi_w(WIDTH);
  localparam int OUT_PW = DW + 2 * NUM;

  logic [OUT_PW-1:0] out_payload;

  generate
    if (!stages_legal(STAGES)) begin : g_bad_stages
      $error("lsu_dc_parity_pipe: STAGES must be 1 or 2");
    end

    if (STAGES == 1) begin : g_s1
      logic [NUM-1:0] par;
      logic [NUM-1:0] err;

      for (genvar gi = 0; gi < NUM; gi++) begin : g_grp
        assign par[gi] = par_reduce(PAR_MAX_W'(in_data[WIDTH*gi +: WIDTH]), in_odd);
      end
      assign err = (par ^ in_par) & {NUM{in_chk}};

      lsu_dc_parity_stage #(.DW(OUT_PW)) u_stage_a (
        .clk         (rclk),
        .reset       (reset),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_payload  ({in_data, par, err}),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_payload (out_payload)
      );
    end else begin : g_s2
      // Stage A carries half-group XORs plus the mode bits; stage B finishes the compare.
      localparam int APW = DW + 3 * NUM + 2;

      logic [NUM-1:0] lo;
      logic [NUM-1:0] hi;
      logic [APW-1:0] a_payload;
      logic           a_vld;
      logic           b_rdy;
      logic [DW-1:0]  a_data;
      logic [NUM-1:0] a_lo;
      logic [NUM-1:0] a_hi;
      logic [NUM-1:0] a_pin;
      logic           a_chk;
      logic           a_odd;
      logic [NUM-1:0] b_par;
      logic [NUM-1:0] b_err;

      for (genvar gi = 0; gi < NUM; gi++) begin : g_grp
        assign lo[gi] = par_reduce(PAR_MAX_W'(in_data[WIDTH*gi +: LO_W]), 1'b0);
        assign hi[gi] = par_reduce(PAR_MAX_W'(in_data[WIDTH*gi+LO_W +: HI_W]), 1'b0);
      end

      lsu_dc_parity_stage #(.DW(APW)) u_stage_a (
        .clk         (rclk),
        .reset       (reset),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_payload  ({in_data, lo, hi, in_par, in_chk, in_odd}),
        .out_vld     (a_vld),
        .out_rdy     (b_rdy),
        .out_payload (a_payload)
      );

      assign a_data = a_payload[APW-1 -: DW];
      assign a_lo   = a_payload[2*NUM+2 +: NUM];
      assign a_hi   = a_payload[NUM+2 +: NUM];
      assign a_pin  = a_payload[2 +: NUM];
      assign a_chk  = a_payload[1];
      assign a_odd  = a_payload[0];
      assign b_par  = a_lo ^ a_hi ^ {NUM{a_odd}};
      assign b_err  = (b_par ^ a_pin) & {NUM{a_chk}};

      lsu_dc_parity_stage #(.DW(OUT_PW)) u_stage_b (
        .clk         (rclk),
        .reset       (reset),
        .in_vld      (a_vld),
        .in_rdy      (b_rdy),
        .in_payload  ({a_data, b_par, b_err}),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_payload (out_payload)
      );
    end
  endgenerate

  assign out_data    = out_payload[OUT_PW-1 -: DW];
  assign out_par     = out_payload[NUM +: NUM];
  assign out_err     = out_payload[NUM-1:0];
  // Gating by out_vld keeps unreset payload bits away from the error flag.
  assign out_any_err = out_vld & (|out_err);

  logic             err_hs;
  logic [CNT_W-1:0] err_cnt_reg;
  logic             err_log_vld_reg;
  logic [NUM-1:0]   err_log_mask_reg;

  assign err_hs = out_vld & out_rdy & out_any_err;

  always_ff @(posedge rclk) begin
    if (reset) begin
      err_cnt_reg      <= '0;
      err_log_vld_reg  <= 1'b0;
      err_log_mask_reg <= '0;
    end else if (err_clr) begin
      // Clear wins on the counter but the concurrent error re-arms the log.
      err_cnt_reg      <= '0;
      err_log_vld_reg  <= err_hs;
      err_log_mask_reg <= err_hs ? out_err : '0;
    end else if (err_hs) begin
      if (err_cnt_reg != '1) begin
        err_cnt_reg <= err_cnt_reg + 1'b1;
      end
      if (!err_log_vld_reg) begin
        err_log_vld_reg  <= 1'b1;
        err_log_mask_reg <= out_err;
      end
    end
  end

  assign err_cnt      = err_cnt_reg;
  assign err_log_vld  = err_log_vld_reg;
  assign err_log_mask = err_log_mask_reg;

endmodule
